// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

    localparam int          REG_W          = 64;
    localparam int          INST_W         = 32;
    localparam logic [63:0] RESET_PC_DEF   = 64'h0000_0000_8000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [REG_W-1:0]  pc;
        logic [INST_W-1:0] inst;
    } ibuf_entry_t;

    function automatic logic [REG_W-1:0] align_pc(input logic [REG_W-1:0] pc);
        return {pc[REG_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/grant/response bus between fetch (master) and memory (slave).
interface if_stage_if;
    import if_stage_pkg::*;

    logic              inst_req;
    logic [REG_W-1:0]  inst_addr;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [INST_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_gnt,
        input  inst_rvalid,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_gnt,
        output inst_rvalid,
        output inst_rdata
    );

endinterface

// File: rtl/if_stage_fifo.sv
// Instruction buffer: power-of-two FIFO with flush; head data reads as zero when empty.
module if_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; validity lives entirely in the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding fetch at a time,
// buffers {pc, inst} pairs for decode and handles redirects from execute.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEF,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    if_stage_if.master        inst_bus,
    input  logic              redirect_valid,
    input  logic [REG_W-1:0]  redirect_pc,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [REG_W-1:0]  if_pc,
    input  logic              id_ready
);

    localparam int CNT_W = $clog2(IBUF_DEPTH) + 1;

    fetch_state_e     state;
    logic [REG_W-1:0] pc_r;
    logic [REG_W-1:0] req_pc;
    logic             drop_r;

    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   occ;
    logic             buf_full;
    logic             buf_empty;
    logic             fire;
    logic             push;
    logic             pop;
    ibuf_entry_t      push_entry;
    ibuf_entry_t      head_entry;

    // An outstanding request reserves a buffer slot so a response never finds the buffer full.
    assign occ = {1'b0, buf_count} + {{CNT_W{1'b0}}, (state == S_WAIT)};

    assign inst_bus.inst_req  = ~rst & (state == S_REQ) & (occ < (CNT_W+1)'(IBUF_DEPTH))
                              & ~redirect_valid;
    assign inst_bus.inst_addr = pc_r;

    assign fire = inst_bus.inst_req & inst_bus.inst_gnt;
    assign push = (state == S_WAIT) & inst_bus.inst_rvalid & ~drop_r & ~redirect_valid & ~buf_full;
    assign pop  = if_valid & id_ready;

    assign push_entry = '{pc: req_pc, inst: inst_bus.inst_rdata};

    assign if_valid = ~rst & ~buf_empty;
    assign if_inst  = head_entry.inst;
    assign if_pc    = head_entry.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_REQ;
            pc_r   <= RESET_PC;
            req_pc <= '0;
            drop_r <= 1'b0;
        end else if (redirect_valid) begin
            pc_r <= align_pc(redirect_pc);
            // A response landing with the redirect is simply discarded; otherwise mark it stale.
            if (state == S_WAIT) begin
                if (inst_bus.inst_rvalid) begin
                    state  <= S_REQ;
                    drop_r <= 1'b0;
                end else begin
                    drop_r <= 1'b1;
                end
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (fire) begin
                        req_pc <= pc_r;
                        pc_r   <= pc_r + 64'd4;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_bus.inst_rvalid) begin
                        drop_r <= 1'b0;
                        state  <= S_REQ;
                    end
                end
            endcase
        end
    end

    if_fifo #(
        .DEPTH (IBUF_DEPTH),
        .WIDTH ($bits(ibuf_entry_t))
    ) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count),
        .head  (head_entry)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory responder, reference scoreboard and test-plan checkpoints.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        gnt_en;
    int          resp_delay;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    always #5 clk = ~clk;

    if_stage_if bus ();
    assign bus.inst_gnt = gnt_en;

    if_stage #(
        .RESET_PC   (RST_PC),
        .IBUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_bus       (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ 32'h8000_0513;
    endfunction

    // Memory responder: captures a grant at the negedge, answers resp_delay cycles later.
    logic        mem_fire;
    logic [63:0] mem_fire_addr;
    int          mem_fire_delay;
    logic        pend = 1'b0;
    logic [63:0] pend_addr;
    int          pend_wait;

    initial begin
        bus.inst_rvalid = 1'b0;
        bus.inst_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_fire       = bus.inst_req & bus.inst_gnt;
            mem_fire_addr  = bus.inst_addr;
            mem_fire_delay = resp_delay;
            @(posedge clk);
            #1;
            bus.inst_rvalid = 1'b0;
            if (mem_fire) begin
                pend      = 1'b1;
                pend_addr = mem_fire_addr;
                pend_wait = mem_fire_delay - 1;
            end
            if (pend) begin
                if (pend_wait == 0) begin
                    bus.inst_rvalid = 1'b1;
                    bus.inst_rdata  = mem_data(pend_addr);
                    pend            = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
        end
    end

    // Reference scoreboard: expected entries pushed on accepted responses, popped on consumption.
    ibuf_entry_t sb[$];
    ibuf_entry_t exp_e;
    logic [63:0] ref_pc     = RST_PC;
    logic [63:0] ref_req_pc = '0;
    logic        ref_wait   = 1'b0;
    logic        ref_drop   = 1'b0;
    logic        exp_req;

    always @(negedge clk) begin
        exp_req = !rst && !ref_wait && (sb.size() < DEPTH) && !redirect_valid;
        check("inst_req", 64'(bus.inst_req), 64'(exp_req));
        if (exp_req) check("inst_addr", bus.inst_addr, ref_pc);
        check("if_valid", 64'(if_valid), 64'(!rst && sb.size() != 0));
        if (!rst && sb.size() != 0) begin
            check("sb_pc", if_pc, sb[0].pc);
            check("sb_inst", 64'(if_inst), 64'(sb[0].inst));
        end
        if (rst) begin
            ref_pc   = RST_PC;
            ref_wait = 1'b0;
            ref_drop = 1'b0;
            sb.delete();
        end else if (redirect_valid) begin
            ref_pc = {redirect_pc[63:2], 2'b00};
            sb.delete();
            if (ref_wait) begin
                if (bus.inst_rvalid) begin
                    ref_wait = 1'b0;
                    ref_drop = 1'b0;
                end else begin
                    ref_drop = 1'b1;
                end
            end
        end else begin
            if (id_ready && sb.size() != 0) begin
                void'(sb.pop_front());
                pops++;
            end
            if (!ref_wait) begin
                if (exp_req && bus.inst_gnt) begin
                    ref_req_pc = ref_pc;
                    ref_pc     = ref_pc + 64'd4;
                    ref_wait   = 1'b1;
                end
            end else if (bus.inst_rvalid) begin
                if (ref_drop) begin
                    ref_drop = 1'b0;
                end else begin
                    exp_e.pc   = ref_req_pc;
                    exp_e.inst = mem_data(ref_req_pc);
                    sb.push_back(exp_e);
                end
                ref_wait = 1'b0;
            end
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    // Waits (from any point) for a condition at a later negedge; 0=req 1=valid 2=rvalid 3=valid&req.
    task automatic wait_for(input int what, input string tag);
        logic hit;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            case (what)
                0:       hit = bus.inst_req;
                1:       hit = if_valid;
                2:       hit = bus.inst_rvalid;
                default: hit = if_valid & bus.inst_req;
            endcase
            if (hit === 1'b1) return;
        end
        checks++;
        errors++;
        $error("FAIL timeout_%s observed=no_event expected=event", tag);
    endtask

    initial begin
        int p0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        gnt_en         = 1'b1;
        resp_delay     = 1;

        // Reset state
        repeat (2) drive();
        @(negedge clk);
        check("rst_req", 64'(bus.inst_req), 64'd0);
        check("rst_valid", 64'(if_valid), 64'd0);
        drive();
        rst = 1'b0;

        // 1: first fetch and 1-cycle response
        wait_for(0, "t1_req");
        check("t1_addr", bus.inst_addr, 64'h8000_0000);
        wait_for(1, "t1_valid");
        check("t1_pc", if_pc, 64'h8000_0000);
        check("t1_inst", 64'(if_inst), 64'h0000_0513);
        check("t1_next_req", 64'(bus.inst_req), 64'd1);
        check("t1_next_addr", bus.inst_addr, 64'h8000_0004);

        // 2: buffer fills to two, request stalls, then drains in order
        repeat (4) @(negedge clk);
        check("t2_stall_req", 64'(bus.inst_req), 64'd0);
        check("t2_head_pc", if_pc, 64'h8000_0000);
        drive();
        id_ready   = 1'b1;
        resp_delay = 4;
        @(negedge clk);
        check("t2_pop0_pc", if_pc, 64'h8000_0000);
        drive();
        id_ready = 1'b0;
        @(negedge clk);
        check("t2_pop1_pc", if_pc, 64'h8000_0004);
        check("t2_resume_req", 64'(bus.inst_req), 64'd1);
        check("t2_resume_addr", bus.inst_addr, 64'h8000_0008);

        // 3: redirect while waiting; late response is dropped
        drive();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1002;
        @(negedge clk);
        check("t3_pre_flush_valid", 64'(if_valid), 64'd1);
        drive();
        redirect_valid = 1'b0;
        resp_delay     = 2;
        @(negedge clk);
        check("t3_flushed", 64'(if_valid), 64'd0);
        check("t3_wait_req", 64'(bus.inst_req), 64'd0);
        wait_for(0, "t3_req");
        check("t3_addr", bus.inst_addr, 64'h8000_1000);
        check("t3_empty", 64'(if_valid), 64'd0);

        // 4: redirect coinciding with the response
        drive();
        drive();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1000;
        @(negedge clk);
        check("t4_rvalid_now", 64'(bus.inst_rvalid), 64'd1);
        drive();
        redirect_valid = 1'b0;
        resp_delay     = 1;
        @(negedge clk);
        check("t4_valid", 64'(if_valid), 64'd0);
        check("t4_req", 64'(bus.inst_req), 64'd1);
        check("t4_addr", bus.inst_addr, 64'h8000_1000);
        wait_for(1, "t4_valid");
        check("t4_pc", if_pc, 64'h8000_1000);
        check("t4_inst", 64'(if_inst), 64'(mem_data(64'h8000_1000)));

        // 5: simultaneous push and pop at count=1, then six in-order pops across wrap
        drive();
        id_ready = 1'b1;
        @(negedge clk);
        check("t5_rvalid", 64'(bus.inst_rvalid), 64'd1);
        check("t5_head_before", if_pc, 64'h8000_1000);
        @(negedge clk);
        check("t5_valid_kept", 64'(if_valid), 64'd1);
        check("t5_head_after", if_pc, 64'h8000_1004);
        p0 = pops;
        for (int i = 0; i < 40 && (pops - p0) < 6; i++) @(negedge clk);
        check("t5_pops", 64'((pops - p0) >= 6), 64'd1);

        // 6: reset while a fetch is outstanding with one entry buffered
        drive();
        id_ready   = 1'b0;
        resp_delay = 6;
        wait_for(3, "t6_setup");
        drive();
        rst    = 1'b1;
        gnt_en = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", 64'(if_valid), 64'd0);
        check("t6_rst_req", 64'(bus.inst_req), 64'd0);
        drive();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", 64'(if_valid), 64'd0);
        check("t6_req", 64'(bus.inst_req), 64'd1);
        check("t6_addr", bus.inst_addr, RST_PC);
        wait_for(2, "t6_stale");
        @(negedge clk);
        check("t6_stale_ignored", 64'(if_valid), 64'd0);
        drive();
        gnt_en     = 1'b1;
        resp_delay = 1;
        wait_for(1, "t6_refetch");
        check("t6_pc", if_pc, RST_PC);
        check("t6_inst", 64'(if_inst), 64'h0000_0513);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
